// File: rtl/pux_si_pkg.sv
// Shared types for the PUX multi-channel stream interface: FSM encoding and
// the layout of the status word.
package pux_si_pkg;

    // Command FSM: wait for opcode, gather/issue tuples, return status.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STAT = 2'd2
    } state_t;

    // Status word is {opcode, count}; the opcode sits above the count field.
    function automatic int stat_opc_lsb(input int dataw, input int opcw);
        return dataw - opcw;
    endfunction

endpackage

// File: rtl/pux_si_fifo.sv
// Synchronous show-ahead FIFO: head always presents the oldest entry, a push
// becomes visible on head the cycle after it is written.
module pux_si_fifo #(
    parameter int DATAW = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             push,
    input  logic [DATAW-1:0] push_data,
    input  logic             pop,
    output logic [DATAW-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage write; pointers alone define validity, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pux_si_mc.sv
// PUX multi-channel stream interface: takes one opcode+length command, gathers
// exactly LEN beats per operand channel, issues LEN aligned tuples to the core
// and returns one status word {opcode, tuple count}.
module pux_si_mc
    import pux_si_pkg::*;
#(
    parameter int OPCW  = 8,
    parameter int DATAW = 16,
    parameter int NBUF  = 3,
    parameter int DEPTH = 4,
    parameter int LENW  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OPCW-1:0]       axis_opcode_data,
    input  logic [LENW-1:0]       axis_opcode_len,
    input  logic                  axis_opcode_valid,
    output logic                  axis_opcode_ready,
    input  logic [NBUF*DATAW-1:0] axis_buf_data,
    input  logic [NBUF-1:0]       axis_buf_valid,
    output logic [NBUF-1:0]       axis_buf_ready,
    output logic [OPCW-1:0]       core_opcode,
    output logic [NBUF*DATAW-1:0] core_data,
    output logic                  core_valid,
    output logic                  core_last,
    input  logic                  core_ready,
    output logic [DATAW-1:0]      axis_status_data,
    output logic                  axis_status_valid,
    input  logic                  axis_status_ready,
    output logic [NBUF-1:0]       stream_request
);
    // Every interface uses valid/ready: a transfer happens on the rising edge
    // where both are high; a source keeps valid and data stable until then.

    localparam int CNTW = DATAW - OPCW;
    localparam int OLSB = stat_opc_lsb(DATAW, OPCW);

    state_t           state;
    logic [OPCW-1:0]  opcode_q;
    logic [LENW:0]    len_q;
    logic [LENW:0]    issued;
    logic [LENW:0]    acc [NBUF];

    logic [NBUF-1:0]  accepting;
    logic [NBUF-1:0]  fifo_full;
    logic [NBUF-1:0]  fifo_empty;
    logic [NBUF-1:0]  push;
    logic [DATAW-1:0] head [NBUF];
    logic             opc_fire;
    logic             core_fire;
    logic             stat_fire;
    logic             last_tuple;
    logic [CNTW-1:0]  cnt_field;

    // A channel takes beats only while it still owes some to the current command.
    always_comb begin
        accepting = '0;
        for (int i = 0; i < NBUF; i++) begin
            accepting[i] = (state == ST_RUN) && (acc[i] < len_q);
        end
    end

    assign stream_request    = accepting;
    assign axis_buf_ready    = accepting & ~fifo_full;
    assign push              = axis_buf_valid & axis_buf_ready;

    assign axis_opcode_ready = (state == ST_IDLE);
    assign opc_fire          = axis_opcode_valid && axis_opcode_ready;

    assign core_valid        = (state == ST_RUN) && (fifo_empty == '0);
    assign last_tuple        = ((issued + (LENW+1)'(1)) == len_q);
    assign core_last         = core_valid && last_tuple;
    assign core_fire         = core_valid && core_ready;
    assign core_opcode       = opcode_q;

    assign axis_status_valid = (state == ST_STAT);
    assign stat_fire         = axis_status_valid && axis_status_ready;
    assign cnt_field         = CNTW'(issued);

    // Status word is only driven while it is being offered.
    always_comb begin
        axis_status_data = '0;
        if (axis_status_valid) begin
            axis_status_data[OLSB +: OPCW] = opcode_q;
            axis_status_data[CNTW-1:0]     = cnt_field;
        end
    end

    // One FIFO per operand channel; all pop together on a core transfer.
    for (genvar g = 0; g < NBUF; g++) begin : g_chan
        pux_si_fifo #(
            .DATAW (DATAW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .flush     (rst),
            .push      (push[g]),
            .push_data (axis_buf_data[g*DATAW +: DATAW]),
            .pop       (core_fire),
            .head      (head[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g])
        );
        assign core_data[g*DATAW +: DATAW] = core_valid ? head[g] : '0;
    end

    // Command FSM with per-channel accept counters and the issued-tuple counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            opcode_q <= '0;
            len_q    <= '0;
            issued   <= '0;
            for (int i = 0; i < NBUF; i++) acc[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (opc_fire) begin
                        opcode_q <= axis_opcode_data;
                        len_q    <= {1'b0, axis_opcode_len};
                        issued   <= '0;
                        for (int i = 0; i < NBUF; i++) acc[i] <= '0;
                        state    <= (axis_opcode_len == '0) ? ST_STAT : ST_RUN;
                    end
                end
                ST_RUN: begin
                    for (int i = 0; i < NBUF; i++) begin
                        if (push[i]) acc[i] <= acc[i] + (LENW+1)'(1);
                    end
                    if (core_fire) begin
                        issued <= issued + (LENW+1)'(1);
                        if (last_tuple) state <= ST_STAT;
                    end
                end
                ST_STAT: begin
                    if (stat_fire) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pux_si_mc.sv
// Directed bench for pux_si_mc: table of commands plus hand-written overrun
// and mid-command reset sequences, checked against an expected-tuple queue.
module tb_pux_si_mc;
    localparam int OPCW  = 8;
    localparam int DATAW = 16;
    localparam int NBUF  = 3;
    localparam int DEPTH = 4;
    localparam int LENW  = 8;
    localparam int TW    = NBUF*DATAW + 1;

    typedef struct {
        logic [OPCW-1:0]                  op;
        int                               len;
        int                               skew_ch;
        int                               skew;
        bit                               toggle;
        int                               stat_hold;
        logic [NBUF-1:0][7:0][DATAW-1:0]  d;
        logic [DATAW-1:0]                 exp_status;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic                  clk;
    logic                  rst;
    logic [OPCW-1:0]       axis_opcode_data;
    logic [LENW-1:0]       axis_opcode_len;
    logic                  axis_opcode_valid;
    logic                  axis_opcode_ready;
    logic [NBUF*DATAW-1:0] axis_buf_data;
    logic [NBUF-1:0]       axis_buf_valid;
    logic [NBUF-1:0]       axis_buf_ready;
    logic [OPCW-1:0]       core_opcode;
    logic [NBUF*DATAW-1:0] core_data;
    logic                  core_valid;
    logic                  core_last;
    logic                  core_ready;
    logic [DATAW-1:0]      axis_status_data;
    logic                  axis_status_valid;
    logic                  axis_status_ready;
    logic [NBUF-1:0]       stream_request;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    pux_si_mc #(.OPCW(OPCW), .DATAW(DATAW), .NBUF(NBUF), .DEPTH(DEPTH), .LENW(LENW)) dut (
        .clk               (clk),
        .rst               (rst),
        .axis_opcode_data  (axis_opcode_data),
        .axis_opcode_len   (axis_opcode_len),
        .axis_opcode_valid (axis_opcode_valid),
        .axis_opcode_ready (axis_opcode_ready),
        .axis_buf_data     (axis_buf_data),
        .axis_buf_valid    (axis_buf_valid),
        .axis_buf_ready    (axis_buf_ready),
        .core_opcode       (core_opcode),
        .core_data         (core_data),
        .core_valid        (core_valid),
        .core_last         (core_last),
        .core_ready        (core_ready),
        .axis_status_data  (axis_status_data),
        .axis_status_valid (axis_status_valid),
        .axis_status_ready (axis_status_ready),
        .stream_request    (stream_request)
    );

    // ---------------- scoreboard state ----------------
    int n_chk;
    int n_fail;
    logic [TW-1:0]          exp_q[$];
    logic [DATAW-1:0]       exp_stat_q[$];
    logic [OPCW+LENW-1:0]   cmd_q[$];
    logic [DATAW-1:0]       bq [NBUF][$];
    int dly [NBUF];
    int acc_cnt [NBUF];
    int pre_b [NBUF];
    int last_req [NBUF];
    bit tog_mode;
    bit tog;
    int stat_hold;
    bit chk_noreq;
    int cyc;
    int stat_cyc;
    int fire_cnt;
    vec_t tbl [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic clear_stats();
        cyc = 0;
        stat_cyc = -1;
        fire_cnt = 0;
        for (int i = 0; i < NBUF; i++) begin
            acc_cnt[i] = 0;
            pre_b[i] = 0;
            last_req[i] = -1;
            dly[i] = 0;
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic cycle();
        logic [NBUF-1:0] bfire;
        logic cfire, sfire, ofire;
        logic [TW-1:0] e;
        for (int i = 0; i < NBUF; i++) begin
            axis_buf_valid[i] = (dly[i] == 0) && (bq[i].size() > 0);
            axis_buf_data[i*DATAW +: DATAW] = axis_buf_valid[i] ? bq[i][0] : '0;
        end
        axis_opcode_valid = (cmd_q.size() > 0);
        {axis_opcode_data, axis_opcode_len} = axis_opcode_valid ? cmd_q[0] : '0;
        core_ready = tog_mode ? tog : 1'b1;
        axis_status_ready = (stat_hold == 0);
        #4;
        bfire = axis_buf_valid & axis_buf_ready;
        cfire = core_valid && core_ready;
        sfire = axis_status_valid && axis_status_ready;
        ofire = axis_opcode_valid && axis_opcode_ready;
        if (cfire) begin
            fire_cnt++;
            if (exp_q.size() == 0) fail_now("unexpected tuple");
            else begin
                e = exp_q.pop_front();
                chk("tuple", 64'({core_last, core_data}), 64'(e));
            end
        end
        if (axis_status_valid) begin
            chk("opcode_ready in STAT", 64'(axis_opcode_ready), 64'd0);
            if (exp_stat_q.size() == 0) fail_now("unexpected status");
            else begin
                chk("status", 64'(axis_status_data), 64'(exp_stat_q[0]));
                if (sfire) begin
                    void'(exp_stat_q.pop_front());
                    stat_cyc = cyc;
                end
            end
        end
        if (chk_noreq) begin
            chk("buf_ready len0", 64'(axis_buf_ready), 64'd0);
            chk("stream_request len0", 64'(stream_request), 64'd0);
        end
        for (int i = 0; i < NBUF; i++) begin
            if (bfire[i] && acc_cnt[1] == 0 && !bfire[1]) pre_b[i]++;
            if (stream_request[i]) last_req[i] = cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NBUF; i++) begin
            if (bfire[i]) begin
                void'(bq[i].pop_front());
                acc_cnt[i]++;
            end
            if (dly[i] > 0) dly[i]--;
        end
        if (ofire) void'(cmd_q.pop_front());
        if (axis_status_valid && stat_hold > 0) stat_hold--;
        tog = ~tog;
        cyc++;
    endtask

    task automatic run_until_done(input string name, input int budget);
        int n;
        n = 0;
        while ((cmd_q.size() > 0 || exp_q.size() > 0 || exp_stat_q.size() > 0) && n < budget) begin
            cycle();
            n++;
        end
        if (n >= budget) begin
            fail_now({name, " timeout"});
            cmd_q.delete();
            exp_q.delete();
            exp_stat_q.delete();
        end
        chk({name, " opcode_ready after"}, 64'(axis_opcode_ready), 64'(cmd_q.size() == 0));
    endtask

    task automatic queue_cmd(input logic [OPCW-1:0] op, input int len,
                             input logic [NBUF-1:0][7:0][DATAW-1:0] d, input int first);
        logic [TW-1:0] e;
        cmd_q.push_back({op, LENW'(len)});
        for (int k = 0; k < len; k++) begin
            e = '0;
            e[TW-1] = (k == len - 1);
            for (int i = 0; i < NBUF; i++) e[i*DATAW +: DATAW] = d[i][first + k];
            exp_q.push_back(e);
        end
    endtask

    task automatic load_beats(input logic [NBUF-1:0][7:0][DATAW-1:0] d, input int n);
        for (int i = 0; i < NBUF; i++)
            for (int k = 0; k < n; k++) bq[i].push_back(d[i][k]);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " opcode_ready"}, 64'(axis_opcode_ready), 64'd1);
        chk({name, " buf_ready"}, 64'(axis_buf_ready), 64'd0);
        chk({name, " stream_request"}, 64'(stream_request), 64'd0);
        chk({name, " core_opcode"}, 64'(core_opcode), 64'd0);
        chk({name, " core_data"}, 64'(core_data), 64'd0);
        chk({name, " core_valid"}, 64'(core_valid), 64'd0);
        chk({name, " core_last"}, 64'(core_last), 64'd0);
        chk({name, " status_data"}, 64'(axis_status_data), 64'd0);
        chk({name, " status_valid"}, 64'(axis_status_valid), 64'd0);
    endtask

    task automatic idle_inputs();
        axis_opcode_valid = 1'b0;
        axis_opcode_data  = '0;
        axis_opcode_len   = '0;
        axis_buf_valid    = '0;
        axis_buf_data     = '0;
        core_ready        = 1'b0;
        axis_status_ready = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- main test ----------------
    initial begin
        logic [NBUF-1:0][7:0][DATAW-1:0] d;
        n_chk = 0;
        n_fail = 0;
        tog_mode = 1'b0;
        tog = 1'b1;
        stat_hold = 0;
        chk_noreq = 1'b0;
        clear_stats();

        // Command table: inputs and the status word each must return.
        foreach (tbl[r]) begin
            tbl[r].skew_ch = 0; tbl[r].skew = 0; tbl[r].toggle = 1'b0;
            tbl[r].stat_hold = 0; tbl[r].d = '0;
        end
        tbl[0].op = 8'h5A; tbl[0].len = 3; tbl[0].exp_status = 16'h5A03;
        tbl[0].d[0][0] = 1;  tbl[0].d[0][1] = 2;  tbl[0].d[0][2] = 3;
        tbl[0].d[1][0] = 10; tbl[0].d[1][1] = 20; tbl[0].d[1][2] = 30;
        tbl[0].d[2][0] = 7;  tbl[0].d[2][1] = 8;  tbl[0].d[2][2] = 9;
        tbl[1].op = 8'h22; tbl[1].len = 8; tbl[1].exp_status = 16'h2208;
        tbl[1].skew_ch = 1; tbl[1].skew = 6;
        tbl[2].op = 8'h33; tbl[2].len = 4; tbl[2].exp_status = 16'h3304;
        tbl[2].toggle = 1'b1; tbl[2].stat_hold = 5;
        tbl[3].op = 8'h11; tbl[3].len = 0; tbl[3].exp_status = 16'h1100;
        for (int i = 0; i < NBUF; i++)
            for (int k = 0; k < 8; k++) begin
                tbl[1].d[i][k] = DATAW'(16'h0100 * (i + 1) + k);
                tbl[2].d[i][k] = DATAW'(16'h0A00 + 16'h0010 * i + k);
            end

        // Reset state.
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Table-driven commands.
        for (int r = 0; r < 4; r++) begin
            clear_stats();
            dly[tbl[r].skew_ch] = tbl[r].skew;
            tog_mode  = tbl[r].toggle;
            tog       = 1'b1;
            stat_hold = tbl[r].stat_hold;
            chk_noreq = (tbl[r].len == 0);
            load_beats(tbl[r].d, tbl[r].len);
            queue_cmd(tbl[r].op, tbl[r].len, tbl[r].d, 0);
            exp_stat_q.push_back(tbl[r].exp_status);
            run_until_done($sformatf("row%0d", r), 300);
            chk("core_opcode held", 64'(core_opcode), 64'(tbl[r].op));
            if (tbl[r].skew > 0) begin
                chk("skew A beats before B", 64'(pre_b[0]), 64'(DEPTH));
                chk("skew M beats before B", 64'(pre_b[2]), 64'(DEPTH));
                chk("skew req B outlasts A", 64'(last_req[1] > last_req[0]), 64'd1);
                chk("skew req B outlasts M", 64'(last_req[1] > last_req[2]), 64'd1);
            end
            if (tbl[r].len == 0) chk("len0 status cycle", 64'(stat_cyc), 64'd1);
            chk_noreq = 1'b0;
            tog_mode = 1'b0;
        end

        // Overrun guard: four beats per channel presented to a len-2 command.
        clear_stats();
        d = '0;
        for (int i = 0; i < NBUF; i++)
            for (int k = 0; k < 4; k++) d[i][k] = DATAW'(16'h5000 + 16'h0100 * i + k);
        load_beats(d, 4);
        queue_cmd(8'h55, 2, d, 0);
        exp_stat_q.push_back(16'h5502);
        run_until_done("overrun cmd1", 100);
        repeat (3) begin
            cycle();
            chk("overrun buf_ready in IDLE", 64'(axis_buf_ready), 64'd0);
        end
        for (int i = 0; i < NBUF; i++) begin
            chk("overrun accepted", 64'(acc_cnt[i]), 64'd2);
            chk("overrun left", 64'(bq[i].size()), 64'd2);
        end
        queue_cmd(8'h56, 2, d, 2);
        exp_stat_q.push_back(16'h5602);
        run_until_done("overrun cmd2", 100);

        // Reset in the middle of a command after its first tuple.
        clear_stats();
        for (int i = 0; i < NBUF; i++)
            for (int k = 0; k < 4; k++) d[i][k] = DATAW'(16'h6000 + 16'h0100 * i + k);
        load_beats(d, 4);
        queue_cmd(8'h66, 4, d, 0);
        begin
            int n;
            n = 0;
            while (fire_cnt < 1 && n < 50) begin
                cycle();
                n++;
            end
            if (n >= 50) fail_now("mid-run first tuple timeout");
        end
        rst = 1'b1;
        for (int i = 0; i < NBUF; i++) bq[i].delete();
        exp_q.delete();
        cmd_q.delete();
        exp_stat_q.delete();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("mid-run reset");
        repeat (4) cycle();
        clear_stats();
        for (int i = 0; i < NBUF; i++) d[i][0] = DATAW'(16'h7000 + i);
        load_beats(d, 1);
        queue_cmd(8'h67, 1, d, 0);
        exp_stat_q.push_back(16'h6701);
        run_until_done("after reset", 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
